mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (CPU / loader) round-robin arbiter in front of a
//               single-port synchronous RAM. Each access runs through
//               IDLE -> ACC -> DATA -> DONE. ACC lasts WAIT_STATES+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  // CPU requester
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_ack,
  // Loader requester
  input  logic        l_req,
  input  logic        l_we,
  input  logic [15:0] l_addr,
  input  logic [15:0] l_wdata,
  output logic        l_ack,
  // Shared status
  output logic [15:0] rdata,
  output logic        busy,
  output logic        owner,
  // Memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value on the final ACC cycle.
  localparam logic [1:0] ACC_LAST = 2'(WAIT_STATES);

  state_t      state;
  logic [1:0]  acc_cnt;
  logic        last_grant;   // 0 = CPU, 1 = loader
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;

  logic        win;          // 0 = CPU, 1 = loader
  logic        win_we;
  logic [15:0] win_addr;
  logic [15:0] win_wdata;

  // Round-robin winner selection; on a tie the side not granted last wins.
  always_comb begin
    win = 1'b0;
    if (c_req && l_req) begin
      win = ~last_grant;
    end else if (l_req) begin
      win = 1'b1;
    end
    win_we    = win ? l_we    : c_we;
    win_addr  = win ? l_addr  : c_addr;
    win_wdata = win ? l_wdata : c_wdata;
  end

  // Latched request drives the memory port and holds outside ACC.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Access sequencer; all strobes are registered and cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc_cnt    <= 2'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rdata      <= 16'h0000;
      lat_we     <= 1'b0;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 16'h0000;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      c_ack      <= 1'b0;
      l_ack      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            owner      <= win;
            last_grant <= win;
            lat_we     <= win_we;
            lat_addr   <= win_addr;
            lat_wdata  <= win_wdata;
            acc_cnt    <= 2'd0;
            mem_en     <= 1'b1;
            mem_we     <= win_we;
            busy       <= 1'b1;
            state      <= ACC;
          end
        end
        ACC: begin
          if (acc_cnt == ACC_LAST) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= DATA;
          end else begin
            acc_cnt <= acc_cnt + 2'd1;
          end
        end
        DATA: begin
          // RAM data is valid here; writes leave rdata untouched.
          if (!lat_we) begin
            rdata <= mem_rdata;
          end
          c_ack <= ~owner;
          l_ack <= owner;
          state <= DONE;
        end
        DONE: begin
          c_ack <= 1'b0;
          l_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
